// File: rtl/ysyx_22041752_sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_sram_arbiter_pkg
// Shared types for the two-master SRAM arbiter.
//   arb_state_e : arbiter FSM state codes (IDLE=0 .. RESP_D=4, 3 bits)
//   owner_e     : which master owns or last owned the SRAM port
//   owner_of()  : maps a busy state to the master it serves
// ---------------------------------------------------------------------------
package ysyx_22041752_sram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_I  = 3'd1,
        ST_RESP_I = 3'd2,
        ST_REQ_D  = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // Owner served by a given state. IDLE has no owner, so it reports ICACHE;
    // callers only use this for non-IDLE states.
    function automatic owner_e owner_of(input arb_state_e st);
        owner_e own;
        case (st)
            ST_REQ_D:  own = OWNER_D;
            ST_RESP_D: own = OWNER_D;
            default:   own = OWNER_I;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/ysyx_22041752_sram_arbiter_pick.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_sram_arbiter_pick
// Combinational winner select for the SRAM arbiter.
// Build option: YSYX_22041752_SRAM_ARB_RR_EN
//   defined   : round-robin; on a tie the master that did not own the last
//               completed transaction wins.
//   undefined : fixed priority, DCACHE over ICACHE; last_owner is ignored.
// A single requester always wins in both builds.
// Ports:
//   i_req      in  ICACHE request
//   d_req      in  DCACHE request
//   last_owner in  owner of the last completed transaction
//   winner     out master to grant (meaningful only when a request is present)
// ---------------------------------------------------------------------------
module ysyx_22041752_sram_arbiter_pick
    import ysyx_22041752_sram_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output owner_e winner
);

`ifdef YSYX_22041752_SRAM_ARB_RR_EN
    // Round-robin select: alternate owners on a tie, otherwise serve the requester.
    always_comb begin
        winner = OWNER_I;
        if (i_req && d_req) begin
            if (last_owner == OWNER_I) begin
                winner = OWNER_D;
            end else begin
                winner = OWNER_I;
            end
        end else if (d_req) begin
            winner = OWNER_D;
        end else begin
            winner = OWNER_I;
        end
    end
`else
    logic unused_last_owner_s;
    assign unused_last_owner_s = last_owner;

    // Fixed-priority select: DCACHE always beats ICACHE.
    always_comb begin
        winner = OWNER_I;
        if (d_req) begin
            winner = OWNER_D;
        end else begin
            winner = OWNER_I;
        end
    end
`endif

endmodule

// File: rtl/ysyx_22041752_sram_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_22041752_sram_arbiter
// Shares one SRAM port between the ICACHE miss path and the DCACHE
// miss/writeback path. One transaction at a time; the grant is held from the
// request phase through the response and is never aborted, even if the owner
// drops its request.
// Build option: YSYX_22041752_SRAM_ARB_RR_EN selects round-robin arbitration
// (with a 1-bit last-owner pointer); default is DCACHE-first fixed priority.
// Ports:
//   clk, reset (async, active-low)
//   ICACHE : i_req, i_addr -> i_ready, i_valid, i_rdata
//   DCACHE : d_req, d_wr, d_addr, d_wdata, d_wstrb -> d_ready, d_valid, d_rdata
//   slave  : s_req, s_wr, s_addr, s_wdata, s_wstrb <- s_ready, s_valid, s_rdata
// ready/valid towards the masters are combinational from the slave so the
// handshake adds no latency; everything else is a decode of the state.
// ---------------------------------------------------------------------------
module ysyx_22041752_sram_arbiter
    import ysyx_22041752_sram_arbiter_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 i_req,
    input  logic [ADDR_WD-1:0]   i_addr,
    output logic                 i_ready,
    output logic                 i_valid,
    output logic [DATA_WD-1:0]   i_rdata,

    input  logic                 d_req,
    input  logic                 d_wr,
    input  logic [ADDR_WD-1:0]   d_addr,
    input  logic [DATA_WD-1:0]   d_wdata,
    input  logic [DATA_WD/8-1:0] d_wstrb,
    output logic                 d_ready,
    output logic                 d_valid,
    output logic [DATA_WD-1:0]   d_rdata,

    output logic                 s_req,
    output logic                 s_wr,
    output logic [ADDR_WD-1:0]   s_addr,
    output logic [DATA_WD-1:0]   s_wdata,
    output logic [DATA_WD/8-1:0] s_wstrb,
    input  logic                 s_ready,
    input  logic                 s_valid,
    input  logic [DATA_WD-1:0]   s_rdata
);

    localparam int STRB_WD = DATA_WD / 8;

    arb_state_e state_r;
    arb_state_e state_n;
    owner_e     winner_s;
    owner_e     last_owner_s;

    ysyx_22041752_sram_arbiter_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_owner (last_owner_s),
        .winner     (winner_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

`ifdef YSYX_22041752_SRAM_ARB_RR_EN
    owner_e last_owner_r;

    // Last-owner pointer, captured whenever a transaction finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner_r <= OWNER_I;
        end else if ((state_r != ST_IDLE) && (state_n == ST_IDLE)) begin
            last_owner_r <= owner_of(state_r);
        end else begin
            last_owner_r <= last_owner_r;
        end
    end

    assign last_owner_s = last_owner_r;
`else
    assign last_owner_s = OWNER_I;
`endif

    // Next state and all outputs. Slave-side fields are zero outside the
    // request phase; read data is zero unless the matching valid is high.
    always_comb begin
        state_n = state_r;
        i_ready = 1'b0;
        i_valid = 1'b0;
        i_rdata = {DATA_WD{1'b0}};
        d_ready = 1'b0;
        d_valid = 1'b0;
        d_rdata = {DATA_WD{1'b0}};
        s_req   = 1'b0;
        s_wr    = 1'b0;
        s_addr  = {ADDR_WD{1'b0}};
        s_wdata = {DATA_WD{1'b0}};
        s_wstrb = {STRB_WD{1'b0}};

        case (state_r)
            ST_IDLE: begin
                // Stray s_ready/s_valid are ignored here.
                if (i_req || d_req) begin
                    if (winner_s == OWNER_D) begin
                        state_n = ST_REQ_D;
                    end else begin
                        state_n = ST_REQ_I;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_REQ_I: begin
                s_req   = i_req;
                s_addr  = i_addr;
                i_ready = s_ready;
                // s_valid without s_ready is not a response to this request.
                if (s_ready) begin
                    if (s_valid) begin
                        i_valid = 1'b1;
                        i_rdata = s_rdata;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RESP_I;
                    end
                end else begin
                    state_n = ST_REQ_I;
                end
            end

            ST_RESP_I: begin
                i_valid = s_valid;
                if (s_valid) begin
                    i_rdata = s_rdata;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP_I;
                end
            end

            ST_REQ_D: begin
                s_req   = d_req;
                s_wr    = d_wr;
                s_addr  = d_addr;
                s_wdata = d_wdata;
                s_wstrb = d_wstrb;
                d_ready = s_ready;
                if (s_ready) begin
                    if (s_valid) begin
                        d_valid = 1'b1;
                        d_rdata = s_rdata;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RESP_D;
                    end
                end else begin
                    state_n = ST_REQ_D;
                end
            end

            ST_RESP_D: begin
                d_valid = s_valid;
                if (s_valid) begin
                    d_rdata = s_rdata;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP_D;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
